// File: rtl/pcm_to_pdm.sv
// pcm_to_pdm: first-order sigma-delta PCM-to-PDM modulator with input FIFO.
// Ports: clk, rst (synchronous, active-high); pcm_data/pcm_valid/pcm_ready
// sample stream; underrun_clr clears the sticky underrun flag; pdm_clk and pdm
// are the generated PDM clock and bitstream; sample_tick pulses one clk after a
// sample is loaded into the modulator; fifo_level reports FIFO occupancy.
// Option: define UNDERRUN_MIDSCALE_EN to load midscale (50% density) on
// underrun; otherwise the last sample keeps being modulated.
module pcm_to_pdm #(
   parameter int BIT_WIDTH          = 8,
   parameter int PDM_CLK_DEC_FACTOR = 12,
   parameter int OSR                = 128,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [BIT_WIDTH-1:0]        pcm_data,
   input  logic                        pcm_valid,
   output logic                        pcm_ready,
   input  logic                        underrun_clr,
   output logic                        pdm_clk,
   output logic                        pdm,
   output logic                        sample_tick,
   output logic                        underrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int DW = $clog2(PDM_CLK_DEC_FACTOR + 1);
   localparam int BW = $clog2(OSR);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t               r_state, w_next;
   logic [DW-1:0]        r_div;
   logic                 r_pdm_clk, r_pdm, r_tick, r_underrun;
   logic [BW-1:0]        r_bit;
   logic [BIT_WIDTH-1:0] r_acc, r_cur;
   logic [BIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_rd, r_wr;
   logic [LW-1:0]        r_level;
   logic                 w_wrap, w_fall, w_bound, w_empty, w_push, w_pop, w_urun;
   logic [BIT_WIDTH:0]   w_sum;
   assign w_wrap  = r_div == DW'(PDM_CLK_DEC_FACTOR - 1);
   assign w_fall  = w_wrap && r_pdm_clk;
   assign w_bound = w_fall && (r_bit == BW'(OSR - 1));
   assign w_empty = r_level == '0;
   assign w_push  = pcm_valid && pcm_ready;
   assign w_sum   = {1'b0, r_acc} + {1'b0, r_cur};
   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   // next state: the first successful pop starts the modulator running
   always_comb begin
      w_next = w_pop ? RUN : r_state;
   end
   // FSM outputs: pop decision uses the registered level, so no empty bypass
   always_comb begin
      w_pop  = w_bound && !w_empty;
      w_urun = w_bound && w_empty && (r_state == RUN);
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= pcm_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div      <= '0;
         r_pdm_clk  <= 1'b0;
         r_pdm      <= 1'b0;
         r_bit      <= '0;
         r_acc      <= '0;
         r_cur      <= '0;
         r_rd       <= '0;
         r_wr       <= '0;
         r_level    <= '0;
         r_tick     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_div <= w_wrap ? '0 : r_div + DW'(1);
         if (w_wrap) r_pdm_clk <= ~r_pdm_clk;
         // the carry of the accumulator add is the PDM bit
         if (w_fall) begin
            {r_pdm, r_acc} <= w_sum;
            r_bit          <= r_bit + BW'(1);
         end
         if (w_pop) r_cur <= r_mem[r_rd];
`ifdef UNDERRUN_MIDSCALE_EN
         else if (w_urun) r_cur <= {1'b1, {(BIT_WIDTH-1){1'b0}}};
`endif
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         r_level    <= r_level + LW'(w_push) - LW'(w_pop);
         r_tick     <= w_pop;
         // a new underrun wins over a simultaneous clear
         r_underrun <= w_urun || (r_underrun && !underrun_clr);
      end
   end
   assign pcm_ready   = r_level < LW'(FIFO_DEPTH);
   assign pdm_clk     = r_pdm_clk;
   assign pdm         = r_pdm;
   assign sample_tick = r_tick;
   assign underrun    = r_underrun;
   assign fifo_level  = r_level;
endmodule

// File: tb/tb_pcm_to_pdm.sv
// tb_pcm_to_pdm: self-checking bench for pcm_to_pdm against a queue/arithmetic model
module tb_pcm_to_pdm;
   localparam int BW  = 8;
   localparam int DEC = 12;
   localparam int OSR = 128;
   localparam int FD  = 4;
   localparam int FRAME = 2 * DEC * OSR;
   logic clk = 0;
   logic rst, pcm_valid, underrun_clr;
   logic [BW-1:0] pcm_data;
   logic pcm_ready, pdm_clk, pdm, sample_tick, underrun;
   logic [$clog2(FD):0] fifo_level;
   pcm_to_pdm #(.BIT_WIDTH(BW), .PDM_CLK_DEC_FACTOR(DEC), .OSR(OSR), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
      .pcm_ready(pcm_ready), .underrun_clr(underrun_clr), .pdm_clk(pdm_clk),
      .pdm(pdm), .sample_tick(sample_tick), .underrun(underrun), .fifo_level(fifo_level)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   // model state: s = clocks since reset, pdm clock derived from s arithmetically
   int s = 0, m_acc = 0, m_cur = 0;
   bit m_pdm = 0, m_tick = 0, m_under = 0, running = 0;
   int q[$];
   // observation of the DUT stream, for hand-computed expectations
   int frames[$], ticks[$], rises[$];
   int nfall = 0, f_ones = 0, ur_s = -1, ur_tick = -1;
   bit prev_pclk = 0, prev_ur = 0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, s);
      end
   endtask
   task automatic model_step();
      int pre, sum;
      bit fall, bnd, pop, ur;
      if (rst) begin
         s = 0; m_acc = 0; m_cur = 0; m_pdm = 0; m_tick = 0; m_under = 0; running = 0;
         q.delete();
      end else begin
         pre  = q.size();
         fall = (s % (2 * DEC)) == 2 * DEC - 1;
         bnd  = fall && ((s / (2 * DEC)) % OSR == OSR - 1);
         pop  = bnd && pre > 0;
         ur   = bnd && pre == 0 && running;
         if (fall) begin
            sum   = m_acc + m_cur;
            m_pdm = sum >= (1 << BW);
            m_acc = sum % (1 << BW);
         end
         if (pop) begin
            m_cur = q.pop_front();
            running = 1;
         end
`ifdef UNDERRUN_MIDSCALE_EN
         else if (ur) m_cur = 1 << (BW - 1);
`endif
         if (pcm_valid && pre < FD) q.push_back(int'(pcm_data));
         m_tick  = pop;
         m_under = ur || (m_under && !underrun_clr);
         s++;
      end
   endtask
   task automatic compare();
      chk("pdm_clk", int'(pdm_clk), (s / DEC) % 2);
      chk("pdm", int'(pdm), int'(m_pdm));
      chk("pcm_ready", int'(pcm_ready), int'(q.size() < FD));
      chk("sample_tick", int'(sample_tick), int'(m_tick));
      chk("underrun", int'(underrun), int'(m_under));
      chk("fifo_level", int'(fifo_level), q.size());
   endtask
   task automatic monitor();
      if (rst) begin
         nfall = 0; f_ones = 0; ur_s = -1; ur_tick = -1; prev_pclk = 0; prev_ur = 0;
         frames.delete(); ticks.delete(); rises.delete();
         return;
      end
      if (prev_pclk && !pdm_clk) begin
         nfall++;
         f_ones += int'(pdm);
         if (nfall % OSR == 0) begin
            frames.push_back(f_ones);
            f_ones = 0;
         end
      end
      if (!prev_pclk && pdm_clk) rises.push_back(s);
      if (sample_tick) ticks.push_back(s);
      if (underrun && !prev_ur && ur_s < 0) begin
         ur_s = s;
         ur_tick = int'(sample_tick);
      end
      prev_pclk = pdm_clk;
      prev_ur   = underrun;
   endtask
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      monitor();
   endtask
   task automatic chk_reset_values(input string tag);
      chk({tag, "_pdm_clk"}, int'(pdm_clk), 0);
      chk({tag, "_pdm"}, int'(pdm), 0);
      chk({tag, "_pcm_ready"}, int'(pcm_ready), 1);
      chk({tag, "_sample_tick"}, int'(sample_tick), 0);
      chk({tag, "_underrun"}, int'(underrun), 0);
      chk({tag, "_fifo_level"}, int'(fifo_level), 0);
   endtask
   logic [BW-1:0] dv [5];
   int i, g;
   bit acc_now, tick_now;
   initial begin
      dv[0] = 8'h80; dv[1] = 8'hFF; dv[2] = 8'h00; dv[3] = 8'h40; dv[4] = 8'h20;
      rst = 1; pcm_valid = 0; pcm_data = '0; underrun_clr = 0;
      step(); step();
      chk_reset_values("reset");
      rst = 0;
      // hold valid with five samples; the fifth must wait for the first pop
      i = 0; g = 0;
      pcm_valid = 1; pcm_data = dv[0];
      while (i < 5 && g < 2 * FRAME) begin
         acc_now  = pcm_ready;
         tick_now = sample_tick;
         step();
         g++;
         if (acc_now) begin
            if (i == 3) begin
               chk("ready_low_after_4", int'(pcm_ready), 0);
               chk("level_after_4", int'(fifo_level), 4);
            end
            if (i == 4) chk("fifth_accept_on_tick", int'(tick_now), 1);
            i++;
            if (i < 5) pcm_data = dv[i];
         end
      end
      pcm_valid = 0;
      chk("all_five_accepted", i, 5);
      for (int k = 0; k < 9 * FRAME && frames.size() < 7; k++) step();
      chk("frames_seen", frames.size(), 7);
      if (frames.size() >= 7) begin
         chk("frame0_idle_ones", frames[0], 0);
         chk("frame1_0x80_ones", frames[1], 64);
         chk("frame2_0xFF_ones", frames[2], 127);
         chk("frame3_0x00_ones", frames[3], 0);
         chk("frame4_0x40_ones", frames[4], 32);
         chk("frame5_0x20_ones", frames[5], 16);
`ifdef UNDERRUN_MIDSCALE_EN
         chk("frame6_underrun_ones", frames[6], 64);
`else
         chk("frame6_underrun_ones", frames[6], 16);
`endif
      end
      chk("rise_count_ok", int'(rises.size() >= 2), 1);
      if (rises.size() >= 2) begin
         chk("first_rise", rises[0], DEC);
         chk("pdm_clk_period", rises[1] - rises[0], 2 * DEC);
      end
      chk("tick_count", ticks.size(), 5);
      if (ticks.size() >= 2) begin
         chk("first_tick", ticks[0], FRAME);
         chk("tick_spacing", ticks[1] - ticks[0], FRAME);
      end
      chk("underrun_time", ur_s, 6 * FRAME);
      chk("underrun_no_tick", ur_tick, 0);
      chk("underrun_held", int'(underrun), 1);
      underrun_clr = 1;
      step();
      underrun_clr = 0;
      chk("underrun_cleared", int'(underrun), 0);
      // random traffic; clears also land on boundary cycles to exercise set-wins
      for (int k = 0; k < 4 * FRAME; k++) begin
         pcm_valid = ($urandom_range(0, 2999) == 0);
         pcm_data  = BW'($urandom);
         underrun_clr = ((s % FRAME) == FRAME - 1) ? 1'($urandom_range(0, 1))
                                                   : ($urandom_range(0, 400) == 0);
         step();
      end
      pcm_valid = 0; underrun_clr = 0;
      // reset mid-frame with three samples queued
      rst = 1; step(); rst = 0;
      pcm_valid = 1;
      for (int k = 0; k < 3; k++) begin
         pcm_data = BW'($urandom);
         step();
      end
      pcm_valid = 0;
      for (int k = 0; k < 1000; k++) step();
      chk("level_before_rst", int'(fifo_level), 3);
      rst = 1; step();
      chk_reset_values("midrst");
      rst = 0;
      for (int k = 0; k < 2 * FRAME + 50; k++) step();
      chk("post_rst_no_ticks", ticks.size(), 0);
      chk("post_rst_no_underrun", int'(underrun), 0);
      if (rises.size() >= 1) chk("post_rst_first_rise", rises[0], DEC);
      else chk("post_rst_rise_seen", rises.size(), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pcm_to_pdm.md
# pcm_to_pdm

PCM-to-PDM modulator for the mic array: accepts unsigned PCM samples over a valid/ready stream and regenerates a 1-bit PDM bitstream with its own PDM clock. It uses a first-order sigma-delta loop at PDM_CLK_DEC_FACTOR / OSR rates, so `pdm_to_pcm` accumulators can capture it directly. It serves as a loopback stimulus source for the microphone front end and as a PDM driver toward a speaker/DAC. A small input FIFO absorbs host burstiness. Underrun is detected and flagged.

## Interface
- BIT_WIDTH, 8: PCM sample width, unsigned offset binary (0 = all zeros, 2^BIT_WIDTH-1 = near all ones).
- PDM_CLK_DEC_FACTOR, 12: clk cycles per pdm_clk half-period (pdm_clk = clk / (2*DEC)).
- OSR, 128: PDM bits per PCM sample (frame length); power of two, ≥2.
- FIFO_DEPTH, 4: input FIFO entries, power of two.
- clk, in, 1: single system clock; all logic on posedge.
- rst, in, 1: synchronous, active-high reset.
- pcm_data, in, BIT_WIDTH: sample to enqueue.
- pcm_valid, in, 1: pcm_data valid.
- pcm_ready, out, 1: FIFO can accept; transfer when valid && ready.
- underrun_clr, in, 1: clears underrun flag.
- pdm_clk, out, 1: generated PDM clock.
- pdm, out, 1: PDM bitstream, changes only on pdm_clk falling transitions.
- sample_tick, out, 1: one-clk pulse when a new sample is loaded into the modulator.
- underrun, out, 1: sticky; FIFO empty at a frame boundary while running.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Divider: div_cnt counts 0..DEC-1. At DEC-1, it wraps and pdm_clk toggles. `pdm_fall` is the cycle where div_cnt==DEC-1 and pdm_clk==1.
- Modulator, on pdm_fall only: {carry, acc} <= acc + cur_sample (BIT_WIDTH+1-bit sum). pdm <= carry. bit_cnt <= bit_cnt+1 mod OSR.
- Frame boundary: pdm_fall with bit_cnt==OSR-1. Any new cur_sample applies from the next bit.
- FIFO: push on pcm_valid && pcm_ready. pcm_ready = (fifo_level < FIFO_DEPTH), derived from registered level. A pop happens only at a frame boundary. When push and pop occur in the same cycle, the level is unchanged and the data ordering is preserved. An empty FIFO has no bypass: a push in the cycle of a boundary pop on empty does not count as that pop.
- States:
  - IDLE (after reset): pdm_clk runs; acc, pdm, and bit_cnt advance with cur_sample=0, so pdm stays 0. At a frame boundary with FIFO non-empty: pop into cur_sample, pulse sample_tick, go to RUN. At a frame boundary with FIFO empty: stay in IDLE, no underrun.
  - RUN: at each frame boundary, pop if non-empty and pulse sample_tick. If empty, set underrun and apply the underrun load (see Configuration); there is no sample_tick and the block stays in RUN.
- underrun_clr clears the flag. If underrun_clr and a new underrun occur in the same cycle, the set wins.

## Timing
- Reset values: pdm_clk=0, pdm=0, pcm_ready=1, sample_tick=0, underrun=0, fifo_level=0. Internally div_cnt=0, bit_cnt=0, acc=0, cur_sample=0, FIFO empty, state IDLE.
- rst mid-frame: all of the above apply on the next posedge and FIFO contents are discarded. The first pdm_clk rise is DEC cycles after rst deasserts.
- pdm_clk period = 2*DEC clk. pdm changes on the clk edge at which pdm_clk falls, giving DEC clk of setup and hold around each pdm_clk rise.
- sample_tick, pop, and fifo_level update are all registered on the boundary cycle and are visible in the following cycle.
- Worst-case latency from push into empty FIFO (IDLE) to first modulated bit: one frame = OSR*2*DEC clk, plus 2*DEC.
- Frame length is exactly OSR pdm_clk periods. With acc continuous across frames, ones per frame averages cur_sample*OSR/2^BIT_WIDTH.

## Configuration
- UNDERRUN_MIDSCALE_EN defined: on underrun, cur_sample <= 2^(BIT_WIDTH-1) (silence, 50% density).
- UNDERRUN_MIDSCALE_EN undefined: on underrun, cur_sample holds its last value.
- The underrun flag behaves identically in both cases.

## Test plan
- Reset, no input -> pdm_clk period 24 clk, pdm=0, pcm_ready=1, fifo_level=0, sample_tick never pulses, underrun stays 0.
- Push 0x80 in IDLE -> sample_tick at next boundary; the following 128 bits alternate 0,1,0,1…, giving exactly 64 ones.
- Push 0xFF then 0x00 (acc=0 at start) -> first frame has 127 ones; second frame has 0 or 1 ones; sample_tick spacing is 3072 clk.
- Hold pcm_valid=1 with 5 samples -> pcm_ready falls after the 4th accept and fifo_level=4. The 5th is accepted the cycle after the first pop. Output order matches input order.
- RUN with FIFO drained -> underrun=1 at the next boundary, with no sample_tick. Without the macro, the previous density continues; with it, density is 64/128. underrun_clr returns the flag to 0.
- rst asserted mid-frame with FIFO level 3 -> next cycle shows all reset values, state IDLE, fifo_level=0.
